// File: rtl/ifns_decode_arbiter_if.sv
// Bundle between the receive lanes, the shared IFNS decoder core and downstream logic.
// slave is the arbiter side; master is the lanes, core and consumer together.
interface ifns_decode_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 14,
   parameter int unsigned DW   = 10
);
   localparam int unsigned CHW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*CW-1:0] req_code;
   logic [NREQ-1:0]    req_ready;
   logic [CW-1:0]      core_codein;
   logic [DW-1:0]      core_dataout;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic [CHW-1:0]     out_chan;
   logic               out_ready;
   logic               busy;

   modport slave (
      input  req_valid, req_code, core_dataout, out_ready,
      output req_ready, core_codein, out_valid, out_data, out_chan, busy
   );

   modport master (
      output req_valid, req_code, core_dataout, out_ready,
      input  req_ready, core_codein, out_valid, out_data, out_chan, busy
   );
endinterface

// File: rtl/ifns_decode_arbiter.sv
// Round-robin front end for one shared combinational IFNS 14->10 decoder core.
// Stage A holds the granted codeword (driving the core); stage B registers the decoded result.
module ifns_decode_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CW   = 14,
   parameter int unsigned DW   = 10
) (
   input  logic                 clock,
   input  logic                 rst,
   ifns_decode_arbiter_if.slave bus
);
   localparam int unsigned CHW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic           r_a_valid;
   logic [CW-1:0]  r_a_code;
   logic [CHW-1:0] r_a_chan;
   logic [CHW-1:0] r_ptr;
   logic           r_out_valid;
   logic [DW-1:0]  r_out_data;
   logic [CHW-1:0] r_out_chan;

   logic           w_b_adv;
   logic           w_a_free;
   logic           w_gnt_any;
   logic [CHW-1:0] w_gnt_idx;
   logic [CW-1:0]  w_gnt_code;

   function automatic logic [CHW-1:0] wrap_idx(input logic [CHW-1:0] base,
                                               input int unsigned off);
      return CHW'((32'(base) + off) % NREQ);
   endfunction

   assign w_b_adv  = r_a_valid & (~r_out_valid | bus.out_ready);
   assign w_a_free = ~r_a_valid | w_b_adv;

   // First valid requester at or after the pointer, only when stage A can take a word.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      if (w_a_free && !rst) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_gnt_any && bus.req_valid[wrap_idx(r_ptr, k)]) begin
               w_gnt_any = 1'b1;
               w_gnt_idx = wrap_idx(r_ptr, k);
            end
         end
      end
   end

   assign w_gnt_code      = bus.req_code[32'(w_gnt_idx) * CW +: CW];
   assign bus.req_ready   = w_gnt_any ? (NREQ'(1) << w_gnt_idx) : '0;
   assign bus.core_codein = r_a_code;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_out_data;
   assign bus.out_chan    = r_out_chan;
   assign bus.busy        = r_a_valid | r_out_valid;

   always_ff @(posedge clock) begin
      if (rst) begin
         r_a_valid   <= 1'b0;
         r_a_code    <= '0;
         r_a_chan    <= '0;
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
      end else begin
         if (w_b_adv) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.core_dataout;
            r_out_chan  <= r_a_chan;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_a_free) begin
            if (w_gnt_any) begin
               r_a_valid <= 1'b1;
               r_a_code  <= w_gnt_code;
               r_a_chan  <= w_gnt_idx;
               r_ptr     <= wrap_idx(w_gnt_idx, 1);
            end else begin
               r_a_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ifns_decode_arbiter.sv
// Randomized scoreboard bench; a stand-in combinational function plays the decoder core.
// The reference tracks in-flight words as an ordered queue with a capacity of two.
module tb_ifns_decode_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned CW   = 14;
   localparam int unsigned DW   = 10;

   typedef struct {
      int unsigned    chan;
      logic [DW-1:0]  data;
      int unsigned    gcyc;
   } exp_t;

   logic clock = 1'b0;
   logic rst   = 1'b1;

   ifns_decode_arbiter_if #(.NREQ(NREQ), .CW(CW), .DW(DW)) bus ();

   ifns_decode_arbiter #(.NREQ(NREQ), .CW(CW), .DW(DW)) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] core_fn(input logic [CW-1:0] c);
      return c[13:4] ^ {c[3:0], c[13:8]} ^ 10'h2A5;
   endfunction

   assign bus.core_dataout = core_fn(bus.core_codein);

   exp_t           sb[$];
   int unsigned    m_ptr    = 0;
   int unsigned    cyc      = 0;
   bit             armed    = 0;
   bit             rst_seen = 0;
   int unsigned    n_checks = 0;
   int unsigned    n_pass   = 0;
   logic [NREQ-1:0] r_v;
   logic [CW-1:0]  codes [NREQ];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Head word is visible once at least one edge has passed since its grant.
   function automatic bit exp_ov();
      return (sb.size() > 0) && (sb[0].gcyc < cyc);
   endfunction

   // Capacity is two words; a word leaving this edge frees a slot.
   function automatic int exp_grant(input logic rstv, input logic [NREQ-1:0] rv, input bit drain);
      int occ;
      occ = int'(sb.size()) - (drain ? 1 : 0);
      if (rstv || occ >= 2) return -1;
      for (int k = 0; k < int'(NREQ); k++)
         if (rv[(int'(m_ptr) + k) % int'(NREQ)]) return (int'(m_ptr) + k) % int'(NREQ);
      return -1;
   endfunction

   // Issue side: record each grant the spec rules predict at this edge.
   initial begin
      int g;
      exp_t e;
      forever begin
         @(posedge clock);
         cyc++;
         if (rst) begin
            sb.delete();
            m_ptr    = 0;
            armed    = 1;
            rst_seen = 1;
         end else begin
            rst_seen = 0;
            g = exp_grant(1'b0, bus.req_valid, 1'b0);
            if (g >= 0) begin
               e.chan = g;
               e.data = core_fn(bus.req_code[g*CW +: CW]);
               e.gcyc = cyc;
               sb.push_back(e);
               m_ptr = (g + 1) % NREQ;
            end
         end
      end
   end

   // Monitor: compare outputs mid-cycle and retire words the consumer accepts.
   initial begin
      bit ov, drain;
      int g;
      logic [NREQ-1:0] exp_rr;
      forever begin
         @(negedge clock);
         if (armed) begin
            ov     = exp_ov();
            drain  = ov && bus.out_ready && !rst;
            g      = exp_grant(rst, bus.req_valid, drain);
            exp_rr = (g < 0) ? '0 : (NREQ'(1) << g);
            check("req_ready", 32'(bus.req_ready), 32'(exp_rr));
            check("out_valid", 32'(bus.out_valid), 32'(ov));
            check("busy", 32'(bus.busy), 32'(sb.size() > 0));
            if (ov) begin
               check("out_data", 32'(bus.out_data), 32'(sb[0].data));
               check("out_chan", 32'(bus.out_chan), sb[0].chan);
            end else if (rst_seen) begin
               check("rst_out_data", 32'(bus.out_data), 32'd0);
               check("rst_out_chan", 32'(bus.out_chan), 32'd0);
            end
            if (drain) void'(sb.pop_front());
         end
      end
   end

   task automatic drive_codes();
      for (int i = 0; i < int'(NREQ); i++) bus.req_code[i*CW +: CW] = codes[i];
      bus.req_valid = r_v;
   endtask

   // One cycle of requester/consumer behaviour; valid holds until granted.
   task automatic step(input logic [NREQ-1:0] mask, input int unsigned pv,
                       input int unsigned pr, input logic rst_v);
      logic [NREQ-1:0] fired;
      @(negedge clock);
      fired = bus.req_valid & bus.req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (fired[i] || !r_v[i]) begin
            r_v[i] = mask[i] && ($urandom_range(99) < pv);
            if (r_v[i]) codes[i] = CW'($urandom);
         end
      end
      drive_codes();
      bus.out_ready = ($urandom_range(99) < pr);
      rst = rst_v;
   endtask

   initial begin
      r_v = '1;
      for (int i = 0; i < int'(NREQ); i++) codes[i] = CW'($urandom);
      drive_codes();
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clock);
      #1 rst = 1'b0;

      repeat (8) step(4'hF, 100, 100, 1'b0);
      repeat (4) step(4'h0, 0, 100, 1'b0);
      step(4'b0100, 100, 100, 1'b0);
      repeat (4) step(4'h0, 0, 100, 1'b0);
      repeat (8) step(4'b1010, 100, 100, 1'b0);
      repeat (4) step(4'h0, 0, 100, 1'b0);
      repeat (3) step(4'b0001, 100, 100, 1'b0);
      repeat (5) step(4'b0001, 100, 0, 1'b0);
      repeat (6) step(4'b0001, 100, 100, 1'b0);
      repeat (3) step(4'hF, 100, 100, 1'b0);
      step(4'hF, 100, 0, 1'b0);
      step(4'hF, 100, 0, 1'b1);
      repeat (6) step(4'hF, 100, 100, 1'b0);
      repeat (2000) step(4'hF, 60, 70, 1'b0);
      repeat (1000) step(4'($urandom), 50, 50, 1'b0);
      repeat (10) step(4'h0, 0, 100, 1'b0);

      @(negedge clock);
      check("final_busy", 32'(bus.busy), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
